// File: rtl/ycbcr_da_pkg.sv
// Shared encodings and constants for the distributed-arithmetic YCbCr channel.
// Contents: mode encoding, FSM state encoding, Q16 coefficient and offset constants.
package ycbcr_da_pkg;

  // Channel selector; MODE_ZERO forces every coefficient and the offset to 0.
  typedef enum logic [1:0] {
    MODE_Y    = 2'd0,
    MODE_CB   = 2'd1,
    MODE_CR   = 2'd2,
    MODE_ZERO = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Coefficients in signed fixed point with 16 fractional bits.
  localparam int signed Y_C0  = 19595;
  localparam int signed Y_C1  = 38470;
  localparam int signed Y_C2  = 7471;
  localparam int signed CB_C0 = -11056;
  localparam int signed CB_C1 = -21712;
  localparam int signed CB_C2 = 32768;
  localparam int signed CR_C0 = 32768;
  localparam int signed CR_C1 = -27440;
  localparam int signed CR_C2 = -5328;

  // Chroma offset in integer units; scaled up by SCALE where it is used.
  localparam int unsigned CHROMA_OFFSET = 128;

endpackage

// File: rtl/da_coef_lut.sv
// Combinational DA partial-sum table: entry[b2 b1 b0] = b0*c0 + b1*c1 + b2*c2.
// Ports: mode_i (coefficient set select), lut_o (8 entries), offset_o (Q.SCALE offset),
// all outputs sign-extended to ACC_WIDTH.
module da_coef_lut
  import ycbcr_da_pkg::*;
#(
  parameter int unsigned COEF_WIDTH = 18,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned SCALE      = 16
) (
  input  mode_e                        mode_i,
  output logic [7:0][ACC_WIDTH-1:0]    lut_o,
  output logic signed [ACC_WIDTH-1:0]  offset_o
);

  logic signed [COEF_WIDTH-1:0] c0, c1, c2;
  logic signed [ACC_WIDTH-1:0]  c0_x, c1_x, c2_x;
  logic                         chroma;

  // Coefficient set select.
  always_comb begin
    c0     = '0;
    c1     = '0;
    c2     = '0;
    chroma = 1'b0;
    case (mode_i)
      MODE_Y: begin
        c0 = COEF_WIDTH'(Y_C0);
        c1 = COEF_WIDTH'(Y_C1);
        c2 = COEF_WIDTH'(Y_C2);
      end
      MODE_CB: begin
        c0     = COEF_WIDTH'(CB_C0);
        c1     = COEF_WIDTH'(CB_C1);
        c2     = COEF_WIDTH'(CB_C2);
        chroma = 1'b1;
      end
      MODE_CR: begin
        c0     = COEF_WIDTH'(CR_C0);
        c1     = COEF_WIDTH'(CR_C1);
        c2     = COEF_WIDTH'(CR_C2);
        chroma = 1'b1;
      end
      default: ;
    endcase
  end

  // Sign-extend and build all eight partial sums.
  always_comb begin
    c0_x     = ACC_WIDTH'(c0);
    c1_x     = ACC_WIDTH'(c1);
    c2_x     = ACC_WIDTH'(c2);
    lut_o    = '0;
    offset_o = '0;
    for (int unsigned e = 0; e < 8; e++) begin
      lut_o[3'(e)] = (e[0] ? c0_x : '0) + (e[1] ? c1_x : '0) + (e[2] ? c2_x : '0);
    end
    if (chroma) offset_o = ACC_WIDTH'(CHROMA_OFFSET) << SCALE;
  end

endmodule

// File: rtl/ycbcr_da_channel.sv
// One RGB->YCbCr output channel computed bit-serially with a DA lookup table.
// Ports: clk/reset_n (sync active-low), in_valid/in_ready + x0..x2 + mode (input triplet),
// out_valid/out_ready + result (saturated channel value), acc_raw (pre-round debug), busy.
module ycbcr_da_channel
  import ycbcr_da_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 8,
  parameter int unsigned COEF_WIDTH  = 18,
  parameter int unsigned SCALE       = 16,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] x0,
  input  logic [INPUT_WIDTH-1:0] x1,
  input  logic [INPUT_WIDTH-1:0] x2,
  input  logic [1:0]             mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   result,
  output logic [ACC_WIDTH-1:0]   acc_raw,
  output logic                   busy
);

  localparam int unsigned CNT_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
  localparam logic signed [ACC_WIDTH-1:0] HALF = ACC_WIDTH'(1) << (SCALE - 1);
  localparam logic signed [ACC_WIDTH-1:0] MAXV = (ACC_WIDTH'(1) << OUT_WIDTH) - ACC_WIDTH'(1);

  state_e                       state_q, state_d;
  logic [INPUT_WIDTH-1:0]       x0_q, x0_d, x1_q, x1_d, x2_q, x2_d;
  mode_e                        mode_q, mode_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]             bit_cnt_q, bit_cnt_d;
  logic [OUT_WIDTH-1:0]         result_q, result_d;
  logic [ACC_WIDTH-1:0]         acc_raw_q, acc_raw_d;
  logic                         out_valid_q, out_valid_d;

  logic [7:0][ACC_WIDTH-1:0]    lut;
  logic signed [ACC_WIDTH-1:0]  offset;
  logic signed [ACC_WIDTH-1:0]  t;
  logic signed [ACC_WIDTH-1:0]  rounded;

  // Table driven only by the captured mode so live port changes cannot disturb a run.
  da_coef_lut #(
    .COEF_WIDTH (COEF_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .SCALE      (SCALE)
  ) u_lut (
    .mode_i   (mode_q),
    .lut_o    (lut),
    .offset_o (offset)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      x1_q        <= '0;
      x2_q        <= '0;
      mode_q      <= MODE_Y;
      acc_q       <= '0;
      bit_cnt_q   <= '0;
      result_q    <= '0;
      acc_raw_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      bit_cnt_q   <= bit_cnt_d;
      result_q    <= result_d;
      acc_raw_q   <= acc_raw_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    bit_cnt_d   = bit_cnt_q;
    result_d    = result_q;
    acc_raw_d   = acc_raw_q;
    out_valid_d = out_valid_q;
    t           = acc_q + offset;
    rounded     = (t + HALF) >>> SCALE;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x0_d      = x0;
          x1_d      = x1;
          x2_d      = x2;
          mode_d    = mode_e'(mode);
          acc_d     = '0;
          bit_cnt_d = CNT_W'(INPUT_WIDTH - 1);
          state_d   = CALC;
        end
      end
      CALC: begin
        // MSB-first: double the running sum, add the partial sum for this bit slice.
        acc_d = (acc_q <<< 1) + lut[{x2_q[bit_cnt_q], x1_q[bit_cnt_q], x0_q[bit_cnt_q]}];
        if (bit_cnt_q == '0) state_d = FINAL;
        else                 bit_cnt_d = bit_cnt_q - CNT_W'(1);
      end
      FINAL: begin
        acc_raw_d = t;
        if (rounded[ACC_WIDTH-1])  result_d = '0;
        else if (rounded > MAXV)   result_d = '1;
        else                       result_d = OUT_WIDTH'(rounded);
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign acc_raw   = acc_raw_q;

endmodule

// File: tb/tb_ycbcr_da_channel.sv
// Self-checking bench for ycbcr_da_channel: directed cases plus randomized triplets
// compared against an arithmetic reference of the channel equation.
module tb_ycbcr_da_channel;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] x0 = '0, x1 = '0, x2 = '0;
  logic [1:0] mode = '0;
  logic       in_ready, out_valid, busy;
  logic [7:0] result;
  logic [31:0] acc_raw;

  int n_checks = 0;
  int n_fail   = 0;

  ycbcr_da_channel dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x0        (x0),
    .x1        (x1),
    .x2        (x2),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .acc_raw   (acc_raw),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: exact channel equation on integers, then round and clamp.
  task automatic model(input int a, input int b, input int c, input int m,
                       output logic signed [63:0] raw, output logic signed [63:0] res);
    longint k0, k1, k2, off, sum, r;
    k0 = 0; k1 = 0; k2 = 0; off = 0;
    case (m)
      0: begin k0 = 19595;  k1 = 38470;  k2 = 7471; end
      1: begin k0 = -11056; k1 = -21712; k2 = 32768;  off = 128 * 65536; end
      2: begin k0 = 32768;  k1 = -27440; k2 = -5328;  off = 128 * 65536; end
      default: ;
    endcase
    sum = k0 * a + k1 * b + k2 * c + off;
    r   = (sum + 32768) >>> 16;
    if (r < 0)   r = 0;
    if (r > 255) r = 255;
    raw = sum;
    res = r;
  endtask

  // One full transaction: accept, optionally scramble inputs during compute,
  // check latency/result, hold backpressure for 'hold' cycles, then release.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [1:0] m, input bit scramble, input int hold);
    logic signed [63:0] exp_raw, exp_res;
    int lat, guard;
    model(int'(a), int'(b), int'(c), int'(m), exp_raw, exp_res);
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    check("ready_before_accept", 64'(in_ready), 1);
    in_valid = 1'b1; x0 = a; x1 = b; x2 = c; mode = m;
    tick();
    in_valid = scramble;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (scramble) begin
        x0 = 8'($urandom); x1 = 8'($urandom); x2 = 8'($urandom); mode = 2'($urandom);
      end
      if (lat == 0) check("busy_in_calc", 64'(busy), 1);
      check("ready_low_while_busy", 64'(in_ready), 0);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 64'(lat), 9);
    check("result", 64'(result), exp_res);
    check("acc_raw", 64'($signed(acc_raw)), exp_raw);
    for (int i = 0; i < hold; i++) begin
      x0 = 8'($urandom); mode = 2'($urandom);
      tick();
      check("hold_valid", 64'(out_valid), 1);
      check("hold_result", 64'(result), exp_res);
      check("hold_ready_low", 64'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_dropped", 64'(out_valid), 0);
    check("ready_returned", 64'(in_ready), 1);
    check("busy_cleared", 64'(busy), 0);
  endtask

  initial begin
    logic signed [63:0] ra, rr, rb_raw, rb_res;
    int lat;

    // Reset state
    reset_n = 1'b0;
    tick(); tick();
    check("rst_in_ready", 64'(in_ready), 1);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_result", 64'(result), 0);
    check("rst_acc_raw", 64'(acc_raw), 0);
    reset_n = 1'b1;
    tick();

    // Directed corner values
    run_txn(8'd255, 8'd255, 8'd255, 2'd0, 1'b0, 0);
    check("y_white_acc_raw", 64'($signed(acc_raw)), 16711680);
    check("y_white_result", 64'(result), 255);
    run_txn(8'd255, 8'd0,   8'd0,   2'd0, 1'b0, 0);
    check("y_red_result", 64'(result), 76);
    run_txn(8'd0,   8'd0,   8'd0,   2'd1, 1'b0, 0);
    check("cb_black_result", 64'(result), 128);
    run_txn(8'd255, 8'd0,   8'd0,   2'd2, 1'b0, 0);
    check("cr_red_sat_result", 64'(result), 255);
    run_txn(8'd0,   8'd0,   8'd255, 2'd2, 1'b0, 0);
    check("cr_blue_result", 64'(result), 107);
    run_txn(8'd200, 8'd17,  8'd99,  2'd3, 1'b0, 0);
    check("zero_mode_result", 64'(result), 0);
    check("zero_mode_acc_raw", 64'(acc_raw), 0);

    // Backpressure for 20 cycles
    run_txn(8'd10, 8'd200, 8'd30, 2'd1, 1'b0, 20);

    // Reset during CALC with bit_cnt at 3
    in_valid = 1'b1; x0 = 8'd50; x1 = 8'd60; x2 = 8'd70; mode = 2'd0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_in_ready", 64'(in_ready), 1);
    check("midrst_out_valid", 64'(out_valid), 0);
    check("midrst_busy", 64'(busy), 0);
    check("midrst_result", 64'(result), 0);
    check("midrst_acc_raw", 64'(acc_raw), 0);
    run_txn(8'd255, 8'd255, 8'd0, 2'd1, 1'b0, 0);
    check("cb_after_rst_result", 64'(result), 1);

    // Inputs and mode churn every cycle while computing
    run_txn(8'd17, 8'd99, 8'd201, 2'd2, 1'b1, 2);

    // Back-to-back: in_valid held high; second triplet only taken once IDLE again
    model(33, 144, 250, 0, ra, rr);
    model(222, 5, 77, 1, rb_raw, rb_res);
    in_valid = 1'b1; x0 = 8'd33; x1 = 8'd144; x2 = 8'd250; mode = 2'd0;
    tick();
    x0 = 8'd222; x1 = 8'd5; x2 = 8'd77; mode = 2'd1;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    check("b2b_first_latency", 64'(lat), 9);
    check("b2b_first_result", 64'(result), rr);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("b2b_idle_ready", 64'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("b2b_second_accepted", 64'(busy), 1);
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    check("b2b_second_latency", 64'(lat), 9);
    check("b2b_second_result", 64'(result), rb_res);
    check("b2b_second_acc_raw", 64'($signed(acc_raw)), rb_raw);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Randomized triplets, modes, churn and backpressure
    for (int n = 0; n < 30; n++) begin
      run_txn(8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ycbcr_da_channel.md
Name: ycbcr_da_channel

Overview:
- Bit-serial distributed-arithmetic dot-product engine for one output channel of the RGB to YCbCr colour conversion.
- Computes out = sat(round((c0*x0 + c1*x1 + c2*x2 + offset) / 2^SCALE)) over three pixel components.
- Uses an 8-entry DA partial-sum LUT instead of multipliers.
- A runtime mode selects the Y, Cb or Cr coefficient set.
- Sits between the pixel input stream and the downsampling/DCT path, with valid/ready handshakes on both sides.

Parameters:
INPUT_WIDTH, 8, unsigned width of each input component
COEF_WIDTH, 18, signed width of each fixed-point coefficient
SCALE, 16, fractional bits of coefficients and offset
ACC_WIDTH, 32, signed accumulator width; must be >= COEF_WIDTH+INPUT_WIDTH+3
OUT_WIDTH, 8, unsigned saturated output width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  synchronous, active-low reset
in_valid  in  1  input triplet valid
in_ready  out  1  block can accept a triplet
x0  in  INPUT_WIDTH  component R
x1  in  INPUT_WIDTH  component G
x2  in  INPUT_WIDTH  component B
mode  in  2  0=Y, 1=Cb, 2=Cr, 3=zero (all coefficients and offset 0)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  OUT_WIDTH  rounded, saturated channel value
acc_raw  out  ACC_WIDTH  signed pre-round accumulator including offset (debug)
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: reset_n sampled low at a rising edge forces the following; this holds even mid-computation or with out_valid pending, and the in-flight result is discarded.
  - state=IDLE
  - in_ready=1, out_valid=0, busy=0
  - result=0, acc_raw=0
  - accumulator=0, bit_cnt=0
- Coefficients (Q.SCALE, signed):
  - Y: 19595, 38470, 7471; offset 0
  - Cb: -11056, -21712, 32768; offset 128<<SCALE
  - Cr: 32768, -27440, -5328; offset 128<<SCALE
- LUT: entry[b2 b1 b0] = b0*c0 + b1*c1 + b2*c2, sign-extended to ACC_WIDTH. The LUT is built from the registered mode only, never the live port.
- FSM:
  - IDLE: in_ready=1. On in_valid & in_ready, register x0..x2 and mode, clear acc, set bit_cnt=INPUT_WIDTH-1, go to CALC.
  - CALC: each cycle acc <= (acc<<<1) + LUT[{x2[bit_cnt],x1[bit_cnt],x0[bit_cnt]}] (MSB first). When bit_cnt==0 go to FINAL, otherwise decrement bit_cnt.
  - FINAL: t = acc + offset. acc_raw <= t. result <= clamp((t + 2^(SCALE-1)) >>> SCALE, 0, 2^OUT_WIDTH-1). out_valid <= 1. Go to DONE.
  - DONE: hold result, acc_raw and out_valid stable. On out_ready, out_valid <= 0 and go to IDLE.
- Latency: out_valid rises INPUT_WIDTH+1 rising edges after the accepting edge (9 for defaults).
- Throughput: at best one result per INPUT_WIDTH+3 cycles.
- in_ready is combinationally (state==IDLE) and does not depend on in_valid.
- Input changes while not IDLE have no effect. Mode changes mid-computation are ignored.
- Arithmetic:
  - Shifts are arithmetic.
  - Negative rounded values clamp to 0; overflow clamps to all-ones.
  - Accumulator overflow cannot occur when ACC_WIDTH meets its minimum.
- Mode 3 yields result 0 and acc_raw 0.
- out_valid is held through any backpressure duration, and result must not change while out_valid=1.

Decomposition:
- Package ycbcr_da_pkg:
  - mode encodings (MODE_Y, MODE_CB, MODE_CR, MODE_ZERO)
  - coefficient and offset constants per mode
  - FSM state encoding (IDLE, CALC, FINAL, DONE)
- Sub-module da_coef_lut: combinational; mode in, 8 LUT entries and offset out, all sign-extended to ACC_WIDTH.
- FSM, accumulator and round/saturate stay in ycbcr_da_channel.

Test Plan:
- mode=Y, (255,255,255) → result=255, acc_raw=16711680, out_valid exactly 9 edges after acceptance.
- mode=Y, (255,0,0) → result=76; mode=Cb, (0,0,0) → result=128.
- mode=Cr, (255,0,0) → rounded value 256 saturates to result=255; mode=Cr, (0,0,255) → result=107.
- Backpressure: out_ready=0 for 20 cycles → out_valid and result stay stable, in_ready=0 throughout. Then out_ready=1 for one cycle → out_valid drops and in_ready returns next cycle.
- Reset mid-operation: reset_n low during CALC (bit_cnt=3) → next cycle IDLE with in_ready=1, out_valid=0, result=0, acc_raw=0. A new Cb (255,255,0) transaction then gives result=1.
- Input/mode stability: change x0..x2 and mode every cycle during CALC → result matches the triplet and mode registered at acceptance. Back-to-back in_valid is accepted only in IDLE. mode=3 gives result=0.
